// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-side pointer and flag controller for an asynchronous FIFO.
// Keeps the binary/Gray write pointer, synchronizes the read pointer into wclk,
// and registers the full, almost-full and conservative occupancy flags.
// Optional feature macro: WFIFO_OVERFLOW_FLAG_EN adds a sticky overflow flag
// (woverflow) cleared by wovf_clr; without it woverflow is tied low.
// ADDRESS_SIZE must be at least 2 so the full comparison has a low-bit field.
module wptr_full_ctrl #(
    parameter int ADDRESS_SIZE = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic                    winc,
    input  logic [ADDRESS_SIZE:0]   rptr,
    input  logic                    wovf_clr,
    output logic [ADDRESS_SIZE-1:0] waddr,
    output logic [ADDRESS_SIZE:0]   wptr,
    output logic                    wfull,
    output logic                    walmost_full,
    output logic [ADDRESS_SIZE:0]   wcount,
    output logic                    woverflow
);

    localparam int PW = ADDRESS_SIZE + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    // Binary to reflected Gray code.
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code back to binary (prefix XOR from the MSB down).
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wq1_rptr;
    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] wbin;

    logic          wr_en_s;
    logic [PW-1:0] wbin_next_s;
    logic [PW-1:0] wgray_next_s;
    logic [PW-1:0] full_ref_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] occupancy_s;
    logic          full_next_s;
    logic          afull_next_s;

    // Next-pointer, full comparison and occupancy, all from the synchronized read pointer.
    always_comb begin
        wr_en_s      = winc && !wfull;
        if (wr_en_s) begin
            wbin_next_s = wbin + {{ADDRESS_SIZE{1'b0}}, 1'b1};
        end else begin
            wbin_next_s = wbin;
        end
        wgray_next_s = bin2gray(wbin_next_s);
        // Full when the write pointer is exactly one lap ahead: the two Gray MSBs differ.
        full_ref_s   = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
        full_next_s  = (wgray_next_s == full_ref_s);
        rbin_s       = gray2bin(wq2_rptr);
        // Modulo-2**PW subtraction handles pointer wrap naturally.
        occupancy_s  = wbin_next_s - rbin_s;
        afull_next_s = (occupancy_s >= AFULL_LVL);
    end

    assign waddr = wbin[ADDRESS_SIZE-1:0];

    // Two-flop synchronizer bringing the Gray read pointer into wclk.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wq1_rptr <= {PW{1'b0}};
            wq2_rptr <= {PW{1'b0}};
        end else begin
            wq1_rptr <= rptr;
            wq2_rptr <= wq1_rptr;
        end
    end

    // Write pointer and registered status flags.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= {PW{1'b0}};
            wptr         <= {PW{1'b0}};
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= {PW{1'b0}};
        end else begin
            wbin         <= wbin_next_s;
            wptr         <= wgray_next_s;
            wfull        <= full_next_s;
            walmost_full <= afull_next_s;
            wcount       <= occupancy_s;
        end
    end

`ifdef WFIFO_OVERFLOW_FLAG_EN
    // Sticky overflow: a rejected write sets it, and setting wins over a same-edge clear.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else if (winc && wfull) begin
            woverflow <= 1'b1;
        end else if (wovf_clr) begin
            woverflow <= 1'b0;
        end else begin
            woverflow <= woverflow;
        end
    end
`else
    logic unused_ovf_clr_s;
    assign unused_ovf_clr_s = wovf_clr;
    assign woverflow        = 1'b0;
`endif

endmodule
